fifo_push_arbiter: RTL and testbench
====================================

// Module: fifo_push_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single push port of the sync FIFO among N_REQ producers.
//  Tracks FIFO occupancy with a credit counter, so pushes never overflow despite registered push.
//  Supports a drain handshake that stops grants until the FIFO is empty.
//  Sits between producer agents and the FIFO push/w_data/pop/valid interface.
// PARAMETERS
//  N_REQ   4                number of requesters, 2..8
//  WIDTH   `Width           data width of w_data
//  DEPTH   2**`Depth_bits   FIFO capacity in entries
// PORTS
//  clk         in   1              single clock; all logic on posedge
//  reset       in   1              synchronous, active-low reset
//  req_valid   in   N_REQ          requester i has data
//  req_data    in   N_REQ*WIDTH    requester i data; slice i = [i*WIDTH +: WIDTH]
//  req_ready   out  N_REQ          one-hot grant; handshake completes when valid&&ready
//  push        out  1              registered push to FIFO
//  w_data      out  WIDTH          registered data to FIFO
//  valid       in   1              FIFO pop accepted this cycle (entry leaves)
//  drain_req   in   1              level request: stop granting, wait for empty
//  drain_done  out  1              one-cycle pulse when drained
//  credits     out  $clog2(DEPTH+1)  free entries as seen by arbiter
// BEHAVIOUR
//  Reset (reset==0 at posedge): push=0, w_data=0, req_ready=0, drain_done=0, credits=DEPTH, rr_ptr=0, state=RUN.
//  Grant (combinational): in RUN with credits>0, req_ready = first asserted req_valid at or after rr_ptr, mod N_REQ.
//   At most one bit set; otherwise 0. req_ready never depends on its own req_valid bit alone.
//  On a grant to i: next cycle push=1, w_data=req_data[i]; rr_ptr <= (i+1) mod N_REQ. No grant: push=0, w_data holds.
//  Latency: accept -> push is exactly 1 cycle; back-to-back grants give push every cycle.
//  Credits: next = credits - grant_any + valid. Simultaneous grant and valid: unchanged.
//   Decrement at grant, not at push, so the in-flight entry is counted. Never below 0 or above DEPTH.
//   valid at credits==DEPTH is a protocol error: saturate and hold.
//  FSM: RUN, DRAIN, DONE.
//   RUN   -> DRAIN on drain_req==1. Grants blocked from the same cycle.
//   DRAIN -> DONE when credits==DEPTH and push==0, i.e. FIFO empty and nothing in flight.
//   DONE  drain_done=1 for one cycle -> RUN if drain_req==0, else stay in DONE with drain_done=0.
//          Leave DONE for RUN when drain_req drops.
//  Reset mid-operation: the in-flight push is dropped. The FIFO is reset by the same reset, so credits=DEPTH is consistent.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//   adds output grant_cnt, N_REQ*16 bits; per-requester grant counters.
//   Counters saturate at 16'hFFFF and clear on reset.
//  FIFO_ARB_STATS_EN undefined: port and counters absent. All other behaviour is identical.
// STRUCTURE
//  fifo_arb_pkg: WIDTH/DEPTH constants from `Width/`Depth_bits, state_t enum {RUN,DRAIN,DONE}, credit_t typedef.
//  Sub-module rr_arbiter: N_REQ-wide rotating-priority grant from req and rr_ptr.
//   Combinational output; pointer register lives in the parent.
// TESTING
//  1 Single requester: req_valid=4'b0010, data 8'hA5 -> req_ready=4'b0010; push=1, w_data=A5 next cycle; credits DEPTH-1.
//  2 All four requesters valid continuously, no pop -> grants 0,1,2,3,0... each 1 cycle.
//    Stop exactly after DEPTH grants; credits=0, req_ready=0.
//  3 Credits=0, valid pulse -> credits=1 and one grant the same cycle.
//    Simultaneous grant+valid keeps credits constant.
//  4 Drain with 3 entries queued: drain_req=1 -> req_ready=0 immediately.
//    After 3 valid pulses, credits=DEPTH; drain_done pulses once; grants resume after drain_req=0.
//  5 Reset asserted during a grant cycle -> next cycle push=0, credits=DEPTH, rr_ptr=0, state RUN.
//  6 With FIFO_ARB_STATS_EN: 10 grants to req2 -> grant_cnt slice 2 ==10, others 0; reset clears all.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the FIFO push arbiter.
// Data width and FIFO depth come from the `Width and `Depth_bits macros (defaults 8 and 3).
`ifndef Width
`define Width 8
`endif
`ifndef Depth_bits
`define Depth_bits 3
`endif

package fifo_arb_pkg;

  localparam int WIDTH    = `Width;
  localparam int DEPTH    = 2 ** `Depth_bits;
  localparam int CREDIT_W = $clog2(DEPTH + 1);

  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t CREDIT_MAX = credit_t'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_push_arbiter_rr_arbiter.sv
// Rotating-priority grant: the first asserted request at or after ptr, wrapping modulo N.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int PTR_W = $clog2(N);

  int               sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter for the sync FIFO push port with credit-based overflow protection and drain handshake.
// Optional per-requester grant counters when FIFO_ARB_STATS_EN is defined.
//   state | meaning
//   RUN   | normal arbitration, grants while credits remain
//   DRAIN | grants blocked, waiting for FIFO empty and no push in flight
//   DONE  | drained; drain_done pulses on entry, back to RUN when drain_req drops
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   push,
  output logic [WIDTH-1:0]       w_data,
  input  logic                   valid,
  input  logic                   drain_req,
  output logic                   drain_done,
`ifdef FIFO_ARB_STATS_EN
  output logic [N_REQ*16-1:0]    grant_cnt,
`endif
  output credit_t                credits
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic             grant_en;
  logic             done_set;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;

  // Drain blocks grants in the very cycle it is requested, before the FSM moves.
  assign grant_en = (state == RUN) && !drain_req && (credits != '0);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_valid & {N_REQ{grant_en}}),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      RUN:   if (drain_req) state_nxt = DRAIN;
      DRAIN: if (credits == CREDIT_MAX && !push) begin
               state_nxt = DONE;
               done_set  = 1'b1;
             end
      DONE:  if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      push       <= 1'b0;
      w_data     <= '0;
      rr_ptr     <= '0;
      credits    <= CREDIT_MAX;
      drain_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_done <= done_set;
      push       <= gnt_any;
      if (gnt_any) begin
        w_data <= req_data[gnt_idx*WIDTH +: WIDTH];
        rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // Debit at grant so the in-flight entry is already counted; a pop at full is ignored.
      if (gnt_any && !valid) begin
        if (credits != '0) credits <= credits - 1'b1;
      end else if (!gnt_any && valid) begin
        if (credits != CREDIT_MAX) credits <= credits + 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stats
    always_ff @(posedge clk) begin
      if (!reset) begin
        grant_cnt[i*16 +: 16] <= '0;
      end else if (gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: cycle-level reference model plus a data scoreboard.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int N = 4;
  localparam int S_RUN = 0, S_DRAIN = 1, S_DONE = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*WIDTH-1:0] req_data = '0;
  logic [N-1:0]     req_ready;
  logic             push;
  logic [WIDTH-1:0] w_data;
  logic             valid = 1'b0;
  logic             drain_req = 1'b0;
  logic             drain_done;
  credit_t          credits;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]  grant_cnt;
`endif

  always #5 clk = ~clk;

  fifo_push_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .push       (push),
    .w_data     (w_data),
    .valid      (valid),
    .drain_req  (drain_req),
    .drain_done (drain_done),
`ifdef FIFO_ARB_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .credits    (credits)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] sb[$];

  int m_credits = DEPTH;
  int m_ptr = 0;
  int m_state = S_RUN;
  int m_push = 0;
  int m_done = 0;
  int m_cnt[N];

  // One clock of stimulus; expected grant predicted before the edge, registered outputs checked after it.
  task automatic cycle(input logic [N-1:0] rv, input logic vld, input logic drn, input logic rst);
    logic [N-1:0]     eg;
    logic [WIDTH-1:0] exp_d;
    int gi, idx, nc, ns, was_reset;
    @(negedge clk);
    req_valid = rv;
    valid     = vld;
    drain_req = drn;
    reset     = rst;
    #1;
    gi = -1;
    if (m_state == S_RUN && !drn && m_credits > 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gi < 0 && ((rv >> idx) & 1) != 0) gi = idx;
      end
    end
    eg = (gi >= 0) ? (N'(1) << gi) : '0;
    vectors++;
    if (req_ready !== eg) begin
      miscompares++;
      $display("FAIL req_ready: got %b expected %b", req_ready, eg);
    end
    if (gi >= 0 && rst) sb.push_back(WIDTH'(req_data >> (gi * WIDTH)));

    @(posedge clk);
    #1;
    was_reset = !rst;
    if (!rst) begin
      m_credits = DEPTH; m_ptr = 0; m_state = S_RUN; m_push = 0; m_done = 0;
      sb.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      ns = m_state;
      m_done = 0;
      case (m_state)
        S_RUN:   if (drn) ns = S_DRAIN;
        S_DRAIN: if (m_credits == DEPTH && m_push == 0) begin ns = S_DONE; m_done = 1; end
        S_DONE:  if (!drn) ns = S_RUN;
        default: ns = S_RUN;
      endcase
      nc = m_credits - ((gi >= 0) ? 1 : 0) + (vld ? 1 : 0);
      if (nc > DEPTH) nc = DEPTH;
      if (nc < 0) nc = 0;
      m_credits = nc;
      m_state = ns;
      m_push = (gi >= 0) ? 1 : 0;
      if (gi >= 0) begin
        m_ptr = (gi + 1) % N;
        if (m_cnt[gi] < 65535) m_cnt[gi]++;
      end
    end

    vectors++;
    if (push !== m_push[0]) begin
      miscompares++;
      $display("FAIL push: got %b expected %0d", push, m_push);
    end
    if (was_reset != 0) begin
      vectors++;
      if (w_data !== '0) begin
        miscompares++;
        $display("FAIL w_data_reset: got %h expected 0", w_data);
      end
    end else if (m_push != 0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL w_data: got %h but no entry expected", w_data);
      end else begin
        exp_d = sb.pop_front();
        if (w_data !== exp_d) begin
          miscompares++;
          $display("FAIL w_data: got %h expected %h", w_data, exp_d);
        end
      end
    end
    vectors++;
    if (credits !== credit_t'(m_credits)) begin
      miscompares++;
      $display("FAIL credits: got %0d expected %0d", credits, m_credits);
    end
    vectors++;
    if (drain_done !== m_done[0]) begin
      miscompares++;
      $display("FAIL drain_done: got %b expected %0d", drain_done, m_done);
    end
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (grant_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
        miscompares++;
        $display("FAIL grant_cnt[%0d]: got %0d expected %0d", i, grant_cnt[i*16 +: 16], m_cnt[i]);
      end
    end
`endif
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic test_reset();
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    req_data = '0;
    req_data[1*WIDTH +: WIDTH] = WIDTH'(8'hA5);
    cycle(4'b0010, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < DEPTH + 3; c++) begin
      randomize_data();
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_credit_return();
    randomize_data();
    cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    randomize_data();
    cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    randomize_data();
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < DEPTH + 2; c++) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_drain();
    for (int c = 0; c < 3; c++) begin
      randomize_data();
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    end
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b1, 1'b1, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    randomize_data();
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    randomize_data();
    cycle(4'b0110, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    randomize_data();
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b1010, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    cycle('0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      randomize_data();
      cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    end
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_credit_return();
    test_drain();
    test_reset_mid();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
